fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the MIPS32 core. It owns the PC and requests instructions from instruction memory. It holds the fetched word in the IF/ID register, and its opcode and funct fields drive the decode-stage control unit directly. Stall, flush and branch/jump redirects from later stages are handled here. A one-entry skid buffer ensures that no accepted instruction is lost while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

- clk  in  1  sole clock, rising edge
- reset_n  in  1  synchronous reset, active low
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address = PC, bits [1:0] always 0
- imem_ready  in  1  memory returns imem_rdata this cycle (same-cycle data, variable wait)
- imem_rdata  in  32  instruction word, valid only when imem_ready=1
- stall  in  1  decode not consuming IF/ID this cycle (hazard unit)
- flush  in  1  squash IF/ID contents
- redirect_valid  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  target; bits [1:0] ignored (forced 0)
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  instruction word; 32'h0 (sll nop) when invalid
- if_id_pc4  out  32  address of that instruction + 4
- opcode  out  6  if_id_instr[31:26], to control unit
- funct  out  6  if_id_instr[5:0], to control unit
- rs, rt, rd  out  5 each  if_id_instr[25:21], [20:16], [15:11]
- imm16  out  16  if_id_instr[15:0]

## Operation
- Registers: pc, state {FETCH, HOLD}, skid_instr, skid_pc4, and IF/ID (valid, instr, pc4).
- imem_req = (state==FETCH) and not in reset. imem_addr = pc at all times.
- Accept = imem_req & imem_ready & ~redirect_valid. An accepted word always advances pc <= pc+4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000).
- Priority each cycle: reset_n=0 > redirect_valid > flush > stall > normal.
- reset_n=0: pc<=RESET_PC, state<=FETCH, if_id_valid<=0, if_id_instr<=0, if_id_pc4<=0, skid cleared.
- redirect_valid=1: pc<=redirect_pc & ~3, state<=FETCH, skid discarded, IF/ID invalidated (instr<=0). Any same-cycle imem response is dropped. redirect implies flush.
- flush=1 (no redirect): IF/ID invalidated. FETCH: an accepted word is still taken; it goes to IF/ID if stall=0, otherwise to the skid (state->HOLD). HOLD: the skid is retained.
- FETCH, stall=0: on accept, IF/ID <= {1, imem_rdata, pc+4}. With no accept, IF/ID <= bubble (valid=0, instr=0).
- FETCH, stall=1: IF/ID unchanged. On accept, skid <= {imem_rdata, pc+4} and state<=HOLD (req drops next cycle).
- HOLD, stall=1: everything unchanged, imem_req=0.
- HOLD, stall=0: IF/ID <= {1, skid}, state<=FETCH. The fetch of pc resumes the following cycle.
- Decoded outputs are pure slices of if_id_instr, with no additional logic.

## Timing
- Fetch-to-decode latency: 1 cycle. A word accepted at edge N is on if_id_* after edge N.
- Zero-wait memory with no stalls gives one instruction per cycle.
- A redirect asserted in cycle N yields imem_addr=target after edge N. The first target instruction reaches IF/ID no earlier than edge N+1.
- Exiting HOLD costs one fetch bubble. IF/ID is then refilled from the skid, with no instruction lost or duplicated.
- A reset asserted mid-wait or in HOLD discards everything and restarts at RESET_PC on the next edge.

## Test plan
- Reset with RESET_PC=0x400 and imem always ready -> imem_addr 0x400, 0x404, 0x408 on consecutive cycles. if_id_pc4 is 0x404 one cycle after 0x400 is fetched; opcode and funct match the word.
- imem_ready held low for 3 cycles -> imem_addr holds; if_id_valid=0 with instr=0 for those cycles; the word is then captured with pc4 correct.
- stall=1 for 4 cycles as 0x08000010 is accepted -> state HOLD, imem_req=0, IF/ID unchanged. After stall drops, IF/ID=0x08000010, then fetch resumes at the next PC.
- redirect_valid with redirect_pc=0x1003 on the same cycle as an imem_ready response -> response dropped, IF/ID invalid, next imem_addr=0x1000.
- flush without redirect while in HOLD -> if_id_valid=0. On stall release the skid instruction still enters IF/ID.
- pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000 and if_id_pc4=0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS32 instruction fetch stage with IF/ID register.
// A one-entry skid buffer keeps a word accepted while decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, pc4;
  logic [31:0] skid_instr, skid_instr_nx;
  logic [31:0] skid_pc4, skid_pc4_nx;
  logic        v_nx;
  logic [31:0] instr_nx, ifpc4_nx;
  logic        accept;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect_valid)
      state_nx = FETCH;
    else if (state == FETCH)
      state_nx = (accept && stall) ? HOLD : FETCH;
    else
      state_nx = (!stall && !flush) ? FETCH : HOLD;
  end

  always_comb begin
    imem_req  = (state == FETCH) && reset_n;
    imem_addr = pc;
    accept    = imem_req && imem_ready && !redirect_valid;
  end

  assign pc4 = pc + 32'd4;

  always_comb begin
    pc_nx         = pc;
    skid_instr_nx = skid_instr;
    skid_pc4_nx   = skid_pc4;
    v_nx          = if_id_valid;
    instr_nx      = if_id_instr;
    ifpc4_nx      = if_id_pc4;
    if (redirect_valid) begin
      pc_nx         = {redirect_pc[31:2], 2'b00};
      skid_instr_nx = '0;
      skid_pc4_nx   = '0;
      v_nx          = 1'b0;
      instr_nx      = '0;
    end else begin
      if (accept) pc_nx = pc4;
      if (state == FETCH) begin
        if (!stall) begin
          v_nx     = accept;
          instr_nx = accept ? imem_rdata : '0;
          if (accept) ifpc4_nx = pc4;
        end else begin
          if (flush) begin
            v_nx     = 1'b0;
            instr_nx = '0;
          end
          if (accept) begin
            skid_instr_nx = imem_rdata;
            skid_pc4_nx   = pc4;
          end
        end
      end else if (flush) begin
        // skid survives a plain flush; only IF/ID is squashed
        v_nx     = 1'b0;
        instr_nx = '0;
      end else if (!stall) begin
        v_nx     = 1'b1;
        instr_nx = skid_instr;
        ifpc4_nx = skid_pc4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      skid_instr  <= '0;
      skid_pc4    <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
    end else begin
      pc          <= pc_nx;
      skid_instr  <= skid_instr_nx;
      skid_pc4    <= skid_pc4_nx;
      if_id_valid <= v_nx;
      if_id_instr <= instr_nx;
      if_id_pc4   <= ifpc4_nx;
    end
  end

  assign opcode = if_id_instr[31:26];
  assign funct  = if_id_instr[5:0];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign imm16  = if_id_instr[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RST = 32'h0000_0400;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_hold;
  logic [31:0] m_sk;
  logic [31:0] m_skpc4;
  logic        m_v;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  fetch_stage #(.RESET_PC(RST)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4),
    .opcode(opcode),
    .funct(funct),
    .rs(rs),
    .rt(rt),
    .rd(rd),
    .imm16(imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one cycle from the current inputs, then clock.
  task automatic tick();
    logic        acc;
    logic [31:0] word;
    logic [31:0] addr;
    acc  = !m_hold && reset_n && imem_ready && !redirect_valid;
    word = imem_rdata;
    addr = m_pc;
    if (!reset_n) begin
      m_pc = RST; m_hold = 0; m_sk = 0; m_skpc4 = 0;
      m_v = 0; m_instr = 0; m_pc4 = 0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc & ~32'h3;
      m_hold = 0; m_v = 0; m_instr = 0;
    end else begin
      if (acc) m_pc = m_pc + 32'd4;
      if (m_hold) begin
        if (flush) begin
          m_v = 0; m_instr = 0;
        end else if (!stall) begin
          m_v = 1; m_instr = m_sk; m_pc4 = m_skpc4; m_hold = 0;
        end
      end else if (acc && stall) begin
        m_sk = word; m_skpc4 = addr + 32'd4; m_hold = 1;
        if (flush) begin m_v = 0; m_instr = 0; end
      end else if (acc) begin
        m_v = 1; m_instr = word; m_pc4 = addr + 32'd4;
      end else if (!stall || flush) begin
        m_v = 0; m_instr = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; imem_ready = 1; imem_rdata = 32'h1234_5678;
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    tick(); tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got %0b want 0", imem_req);
    end
    checks++;
    if (imem_addr !== RST || if_id_valid !== 1'b0 || if_id_instr !== 32'h0
        || if_id_pc4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state addr %h v %0b instr %h pc4 %h want %h 0 0 0",
               imem_addr, if_id_valid, if_id_instr, if_id_pc4, RST);
    end
    reset_n = 1;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL reset_release_req got %0b want 1", imem_req);
    end
  endtask

  task automatic test_stream();
    logic [31:0] w [3];
    w[0] = 32'h8C43_0004;
    w[1] = 32'h0085_1020;
    w[2] = 32'h1062_FFFD;
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1; imem_rdata = w[i];
      checks++;
      if (imem_addr !== RST + 32'(4 * i)) begin
        errors++;
        $display("FAIL stream_addr%0d got %h want %h", i, imem_addr, RST + 32'(4 * i));
      end
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== w[i]
          || if_id_pc4 !== RST + 32'(4 * i + 4)) begin
        errors++;
        $display("FAIL stream_ifid%0d got %0b %h %h want 1 %h %h", i,
                 if_id_valid, if_id_instr, if_id_pc4, w[i], RST + 32'(4 * i + 4));
      end
      checks++;
      if (opcode !== w[i][31:26] || funct !== w[i][5:0]
          || rs !== w[i][25:21] || rt !== w[i][20:16] || rd !== w[i][15:11]) begin
        errors++;
        $display("FAIL stream_fields%0d got op %h fn %h want %h %h", i,
                 opcode, funct, w[i][31:26], w[i][5:0]);
      end
    end
  endtask

  task automatic test_wait();
    for (int i = 0; i < 3; i++) begin
      imem_ready = 0; imem_rdata = $urandom;
      tick();
      checks++;
      if (imem_addr !== 32'h40C || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
        errors++;
        $display("FAIL wait%0d got addr %h v %0b instr %h want 40c 0 0",
                 i, imem_addr, if_id_valid, if_id_instr);
      end
    end
    imem_ready = 1; imem_rdata = 32'h2108_FFFF;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h2108_FFFF
        || if_id_pc4 !== 32'h410 || imm16 !== 16'hFFFF) begin
      errors++;
      $display("FAIL wait_capture got %0b %h %h %h want 1 2108ffff 410 ffff",
               if_id_valid, if_id_instr, if_id_pc4, imm16);
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] nxt;
    stall = 1; imem_ready = 1; imem_rdata = 32'h0800_0010;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b0 || if_id_valid !== 1'b1
          || if_id_instr !== 32'h2108_FFFF || if_id_pc4 !== 32'h410) begin
        errors++;
        $display("FAIL hold%0d got req %0b v %0b instr %h pc4 %h want 0 1 2108ffff 410",
                 i, imem_req, if_id_valid, if_id_instr, if_id_pc4);
      end
      if (i < 3) begin
        imem_ready = 1'($urandom); imem_rdata = $urandom;
        tick();
      end
    end
    stall = 0;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0800_0010
        || if_id_pc4 !== 32'h414 || imem_req !== 1'b1 || imem_addr !== 32'h414) begin
      errors++;
      $display("FAIL hold_release got %0b %h %h req %0b addr %h want 1 08000010 414 1 414",
               if_id_valid, if_id_instr, if_id_pc4, imem_req, imem_addr);
    end
    nxt = $urandom;
    imem_ready = 1; imem_rdata = nxt;
    tick();
    checks++;
    if (if_id_instr !== nxt || if_id_pc4 !== 32'h418) begin
      errors++;
      $display("FAIL hold_resume got %h %h want %h 418", if_id_instr, if_id_pc4, nxt);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] w;
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1; redirect_pc = 32'h1003;
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'h1000
        || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL redirect got v %0b instr %h addr %h req %0b want 0 0 1000 1",
               if_id_valid, if_id_instr, imem_addr, imem_req);
    end
    redirect_valid = 0;
    w = $urandom; imem_rdata = w;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== w || if_id_pc4 !== 32'h1004) begin
      errors++;
      $display("FAIL redirect_target got %0b %h %h want 1 %h 1004",
               if_id_valid, if_id_instr, if_id_pc4, w);
    end
  endtask

  task automatic test_flush_hold();
    stall = 1; imem_ready = 1; imem_rdata = 32'h3C01_1234;
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL flush_hold_enter req %0b want 0", imem_req);
    end
    flush = 1;
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold got v %0b instr %h req %0b want 0 0 0",
               if_id_valid, if_id_instr, imem_req);
    end
    flush = 0; stall = 0;
    tick();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h3C01_1234 || if_id_pc4 !== 32'h1008) begin
      errors++;
      $display("FAIL flush_hold_release got %0b %h %h want 1 3c011234 1008",
               if_id_valid, if_id_instr, if_id_pc4);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE; imem_ready = 0;
    tick();
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_load got %h want fffffffc", imem_addr);
    end
    redirect_valid = 0; imem_ready = 1; imem_rdata = 32'h0000_0000;
    tick();
    checks++;
    if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap got addr %h pc4 %h v %0b want 0 0 1",
               imem_addr, if_id_pc4, if_id_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset_n        = ($urandom_range(0, 59) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      flush          = ($urandom_range(0, 9) == 0);
      stall          = ($urandom_range(0, 2) == 0);
      imem_ready     = ($urandom_range(0, 2) != 0);
      imem_rdata     = $urandom;
      tick();
      checks++;
      if (imem_req !== (!m_hold && reset_n) || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL rand_fetch c%0d got req %0b addr %h want %0b %h",
                 i, imem_req, imem_addr, !m_hold && reset_n, m_pc);
      end
      checks++;
      if (if_id_valid !== m_v || if_id_instr !== m_instr
          || (m_v && if_id_pc4 !== m_pc4) || opcode !== m_instr[31:26]
          || funct !== m_instr[5:0]) begin
        errors++;
        $display("FAIL rand_ifid c%0d got %0b %h %h want %0b %h %h",
                 i, if_id_valid, if_id_instr, if_id_pc4, m_v, m_instr, m_pc4);
      end
    end
  endtask

  initial begin
    m_pc = RST; m_hold = 0; m_sk = 0; m_skpc4 = 0;
    m_v = 0; m_instr = 0; m_pc4 = 0;
    reset_n = 0; imem_ready = 0; imem_rdata = 0;
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    test_reset();
    test_stream();
    test_wait();
    test_stall_hold();
    test_redirect();
    test_flush_hold();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
